// File: rtl/mem_timer_pkg.sv
// Shared register offsets and CTRL bit positions for the memory-mapped machine timer.
package mem_timer_pkg;

    localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
    localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
    localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TMR_CTRL        = 3'd4;
    localparam logic [2:0] TMR_STATUS      = 3'd5;

    localparam int TMR_CTRL_EN      = 0;
    localparam int TMR_CTRL_IE      = 1;
    localparam int TMR_CTRL_DIV_LSB = 8;

endpackage

// File: rtl/mem_timer_byte_merge.sv
// Byte-lane masked merge: each lane with its mask bit set takes the new data,
// the others keep the old value.
module byte_merge
    import mem_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   i_old,
    input  logic [W-1:0]   i_new,
    input  logic [W/8-1:0] i_mask,
    output logic [W-1:0]   o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < W/8; i++) begin
            if (i_mask[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare and a level interrupt.
// Bus reads are combinational; writes, snapshot and counting commit on the clock edge.
module mem_timer
    import mem_timer_pkg::*;
#(
    parameter int          PRESCALE_W = 8,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wrData,
    input  logic [3:0]  wrMask,
    output logic [31:0] rdData,
    output logic        irq
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [31:0]           r_hi_shadow;
    logic                  r_en;
    logic                  r_ie;
    logic [PRESCALE_W-1:0] r_div;
    logic [PRESCALE_W-1:0] r_count;
    logic                  r_pend;
    logic                  r_match_q;

    logic [2:0]            w_idx;
    logic                  w_wr;
    logic                  w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_status;
    logic                  w_tick, w_match, w_pend_set, w_pend_clr;
    logic [31:0]           w_mlo_new, w_mhi_new, w_clo_new, w_chi_new;
    logic [PRESCALE_W-1:0] w_div_next;
    logic [31:0]           w_ctrl_rd;
    logic                  w_unused;

    assign w_unused    = ^addr[1:0];
    assign w_idx       = addr[4:2];
    assign w_wr        = sel & we;
    assign w_wr_mlo    = w_wr && (w_idx == TMR_MTIME_LO);
    assign w_wr_mhi    = w_wr && (w_idx == TMR_MTIME_HI);
    assign w_wr_clo    = w_wr && (w_idx == TMR_MTIMECMP_LO);
    assign w_wr_chi    = w_wr && (w_idx == TMR_MTIMECMP_HI);
    assign w_wr_ctrl   = w_wr && (w_idx == TMR_CTRL);
    assign w_wr_status = w_wr && (w_idx == TMR_STATUS);

    assign w_tick      = r_en && (r_count == r_div);
    assign w_match     = (r_mtime >= r_mtimecmp);
    assign w_pend_set  = w_match & ~r_match_q;
    assign w_pend_clr  = w_wr_status & wrMask[0] & wrData[0];

    byte_merge #(.W(32)) u_merge_mlo (.i_old(r_mtime[31:0]),     .i_new(wrData), .i_mask(wrMask), .o_merged(w_mlo_new));
    byte_merge #(.W(32)) u_merge_mhi (.i_old(r_mtime[63:32]),    .i_new(wrData), .i_mask(wrMask), .o_merged(w_mhi_new));
    byte_merge #(.W(32)) u_merge_clo (.i_old(r_mtimecmp[31:0]),  .i_new(wrData), .i_mask(wrMask), .o_merged(w_clo_new));
    byte_merge #(.W(32)) u_merge_chi (.i_old(r_mtimecmp[63:32]), .i_new(wrData), .i_mask(wrMask), .o_merged(w_chi_new));

    // The divisor field may straddle byte lanes, so pick each bit's lane individually.
    always_comb begin
        w_div_next = r_div;
        for (int k = 0; k < PRESCALE_W; k++) begin
            if (wrMask[(TMR_CTRL_DIV_LSB + k) / 8]) w_div_next[k] = wrData[TMR_CTRL_DIV_LSB + k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime     <= '0;
            r_mtimecmp  <= CMP_RESET;
            r_hi_shadow <= '0;
            r_en        <= 1'b0;
            r_ie        <= 1'b0;
            r_div       <= '0;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_match_q   <= 1'b0;
        end else begin
            r_match_q <= w_match;
            r_pend    <= w_pend_set | (r_pend & ~w_pend_clr);

            if (sel && !we && (w_idx == TMR_MTIME_LO)) r_hi_shadow <= r_mtime[63:32];

            // A software write to either half wins over the tick for the whole counter.
            if (w_wr_mlo)      r_mtime[31:0]  <= w_mlo_new;
            else if (w_wr_mhi) r_mtime[63:32] <= w_mhi_new;
            else if (w_tick)   r_mtime        <= r_mtime + 64'd1;

            if (w_wr_clo) r_mtimecmp[31:0]  <= w_clo_new;
            if (w_wr_chi) r_mtimecmp[63:32] <= w_chi_new;

            if (w_wr_ctrl) begin
                if (wrMask[0]) r_en <= wrData[TMR_CTRL_EN];
                if (wrMask[0]) r_ie <= wrData[TMR_CTRL_IE];
                r_div <= w_div_next;
            end

            if (w_wr_ctrl || w_wr_mlo || w_wr_mhi || !r_en || w_tick) r_count <= '0;
            else                                                    r_count <= r_count + PRESCALE_W'(1);
        end
    end

    always_comb begin
        w_ctrl_rd = '0;
        w_ctrl_rd[TMR_CTRL_EN] = r_en;
        w_ctrl_rd[TMR_CTRL_IE] = r_ie;
        w_ctrl_rd[TMR_CTRL_DIV_LSB +: PRESCALE_W] = r_div;
    end

    always_comb begin
        rdData = '0;
        if (sel && !reset) begin
            case (w_idx)
                TMR_MTIME_LO:    rdData = r_mtime[31:0];
                TMR_MTIME_HI:    rdData = r_hi_shadow;
                TMR_MTIMECMP_LO: rdData = r_mtimecmp[31:0];
                TMR_MTIMECMP_HI: rdData = r_mtimecmp[63:32];
                TMR_CTRL:        rdData = w_ctrl_rd;
                TMR_STATUS:      rdData = {31'b0, r_pend};
                default:         rdData = '0;
            endcase
        end
    end

    assign irq = r_pend & r_ie & ~reset;

endmodule

// File: tb/tb_mem_timer.sv
// Self-checking bench for mem_timer: directed scenarios plus randomized bus traffic
// compared against a cycle-level behavioural model of the timer.
module tb_mem_timer;

    logic        clk = 1'b0;
    logic        reset, sel, we;
    logic [4:0]  addr;
    logic [31:0] wrData;
    logic [3:0]  wrMask;
    logic [31:0] rdData;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_ctrl, m_shadow;
    int          m_cnt;
    logic        m_pend, m_matchq;

    logic [31:0] obs_rd, exp_rd;
    logic        obs_irq, exp_irq;

    always #5 clk = ~clk;

    mem_timer #(.PRESCALE_W(8), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wrData(wrData), .wrMask(wrMask), .rdData(rdData), .irq(irq)
    );

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic s, input logic [4:0] a);
        if (!s) return 32'h0;
        case (a[4:2])
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return m_ctrl;
            3'd5: return {31'b0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] m);
        logic en, tick, match, wr;
        logic [2:0] idx;
        if (r) begin
            m_mtime = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ctrl = 32'h0;
            m_shadow = 32'h0; m_cnt = 0; m_pend = 1'b0; m_matchq = 1'b0;
            return;
        end
        en    = m_ctrl[0];
        tick  = en && (m_cnt == int'(m_ctrl[15:8]));
        match = (m_mtime >= m_cmp);
        wr    = s && w;
        idx   = a[4:2];
        if (match && !m_matchq)                     m_pend = 1'b1;
        else if (wr && idx == 3'd5 && m[0] && d[0]) m_pend = 1'b0;
        m_matchq = match;
        if (s && !w && idx == 3'd0) m_shadow = m_mtime[63:32];
        if ((wr && (idx == 3'd0 || idx == 3'd1 || idx == 3'd4)) || !en || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (wr && idx == 3'd0)      m_mtime[31:0]  = merge32(m_mtime[31:0], d, m);
        else if (wr && idx == 3'd1) m_mtime[63:32] = merge32(m_mtime[63:32], d, m);
        else if (tick)              m_mtime = m_mtime + 64'd1;
        if (wr && idx == 3'd2) m_cmp[31:0]  = merge32(m_cmp[31:0], d, m);
        if (wr && idx == 3'd3) m_cmp[63:32] = merge32(m_cmp[63:32], d, m);
        if (wr && idx == 3'd4) m_ctrl = merge32(m_ctrl, d, m) & 32'h0000_FF03;
    endtask

    // One bus cycle: drive, sample at the falling edge, then advance the model at the rising edge.
    task automatic bus(input logic r, input logic s, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        reset = r; sel = s; we = w; addr = a; wrData = d; wrMask = m;
        exp_rd  = r ? 32'h0 : model_read(s, a);
        exp_irq = r ? 1'b0 : (m_pend & m_ctrl[1]);
        @(negedge clk);
        obs_rd = rdData; obs_irq = irq;
        @(posedge clk);
        model_edge(r, s, w, a, d, m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, 1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [4:0] a);
        bus(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        bus(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        logic [31:0] tab [8];
        tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4));
            checks++;
            if (obs_rd !== tab[i]) begin
                errors++; $display("FAIL reset_read[%0d] got=%h want=%h", i, obs_rd, tab[i]);
            end
            checks++;
            if (obs_irq !== 1'b0) begin
                errors++; $display("FAIL reset_irq[%0d] got=%b want=0", i, obs_irq);
            end
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        wr(5'h10, 32'h0000_0301);
        idle(40);
        rd(5'h00);
        checks++;
        if (obs_rd < 32'd9 || obs_rd > 32'd11) begin
            errors++; $display("FAIL prescale_rate got=%0d want=10(+-1)", obs_rd);
        end
        checks++;
        if (obs_rd !== 32'd10) begin
            errors++; $display("FAIL prescale_exact got=%0d want=10", obs_rd);
        end
        for (int i = 0; i < 8; i++) begin
            rd(5'h00);
            checks++;
            if (obs_rd !== exp_rd) begin
                errors++; $display("FAIL prescale_step[%0d] got=%0d want=%0d", i, obs_rd, exp_rd);
            end
        end
    endtask

    task automatic test_wrap_snapshot();
        do_reset();
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h10, 32'h0000_0001);
        rd(5'h04);
        checks++;
        if (obs_rd !== 32'h0) begin
            errors++; $display("FAIL hi_is_shadow got=%h want=00000000", obs_rd);
        end
        idle(2);
        rd(5'h00);
        checks++;
        if (obs_rd !== 32'h1) begin
            errors++; $display("FAIL wrap_lo got=%h want=00000001", obs_rd);
        end
        rd(5'h04);
        checks++;
        if (obs_rd !== 32'h0) begin
            errors++; $display("FAIL wrap_hi got=%h want=00000000", obs_rd);
        end
        idle(2);
        rd(5'h04);
        checks++;
        if (obs_rd !== 32'h0) begin
            errors++; $display("FAIL hi_reread got=%h want=00000000", obs_rd);
        end
    endtask

    task automatic test_byte_mask();
        do_reset();
        bus(1'b0, 1'b1, 1'b1, 5'h08, 32'hAABB_CCDD, 4'b0100);
        rd(5'h08);
        checks++;
        if (obs_rd !== 32'hFFBB_FFFF) begin
            errors++; $display("FAIL byte_mask got=%h want=FFBBFFFF", obs_rd);
        end
    endtask

    task automatic test_irq_flow();
        int first;
        do_reset();
        wr(5'h08, 32'h10);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h3);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            rd(5'h14);
            checks++;
            if (obs_rd !== exp_rd || obs_irq !== exp_irq) begin
                errors++; $display("FAIL irq_track[%0d] got=%h/%b want=%h/%b", i, obs_rd, obs_irq, exp_rd, exp_irq);
            end
            if (obs_rd[0] === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first != 17) begin
            errors++; $display("FAIL pend_time got=%0d want=17", first);
        end
        checks++;
        if (obs_irq !== 1'b1) begin
            errors++; $display("FAIL irq_assert got=%b want=1", obs_irq);
        end
        wr(5'h14, 32'h1);
        rd(5'h14);
        checks++;
        if (obs_rd !== 32'h0 || obs_irq !== 1'b0) begin
            errors++; $display("FAIL pend_clear got=%h/%b want=0/0", obs_rd, obs_irq);
        end
        wr(5'h08, 32'h5);
        idle(2);
        rd(5'h14);
        checks++;
        if (obs_rd !== 32'h0) begin
            errors++; $display("FAIL lower_cmp_no_pend got=%h want=0", obs_rd);
        end
        wr(5'h00, 32'h0);
        wr(5'h08, 32'h3);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            rd(5'h14);
            if (obs_rd[0] === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first != 3) begin
            errors++; $display("FAIL pend_rearm got=%0d want=3", first);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        wr(5'h08, 32'h8);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h1);
        idle(8);
        bus(1'b0, 1'b1, 1'b1, 5'h14, 32'h1, 4'h1);
        rd(5'h14);
        checks++;
        if (obs_rd !== 32'h1) begin
            errors++; $display("FAIL set_beats_clear got=%h want=1", obs_rd);
        end

        do_reset();
        wr(5'h10, 32'h1);
        wr(5'h00, 32'h100);
        rd(5'h00);
        checks++;
        if (obs_rd !== 32'h100) begin
            errors++; $display("FAIL write_beats_tick got=%h want=00000100", obs_rd);
        end

        do_reset();
        wr(5'h10, 32'h3);
        bus(1'b1, 1'b1, 1'b1, 5'h08, 32'h1234, 4'hF);
        checks++;
        if (obs_rd !== 32'h0 || obs_irq !== 1'b0) begin
            errors++; $display("FAIL out_in_reset got=%h/%b want=0/0", obs_rd, obs_irq);
        end
        rd(5'h08);
        checks++;
        if (obs_rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_discard got=%h want=FFFFFFFF", obs_rd);
        end
        rd(5'h10);
        checks++;
        if (obs_rd !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl got=%h want=0", obs_rd);
        end
    endtask

    task automatic test_random();
        logic r, s, w;
        logic [4:0] a;
        logic [31:0] d;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            case (a[4:2])
                3'd0, 3'd2: if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 63);
                3'd1, 3'd3: if ($urandom_range(0, 3) != 0) d = 32'h0;
                3'd4:       d = {16'h0, 8'($urandom_range(0, 3)), 6'h0, 2'($urandom_range(0, 3))};
                default:    ;
            endcase
            bus(r, s, w, a, d, 4'($urandom_range(0, 15)));
            checks++;
            if (obs_rd !== exp_rd || obs_irq !== exp_irq) begin
                errors++; $display("FAIL random[%0d] a=%h got=%h/%b want=%h/%b", n, a, obs_rd, obs_irq, exp_rd, exp_irq);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wrData = '0; wrMask = '0;
        model_edge(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_prescaler();
        test_wrap_snapshot();
        test_byte_mask();
        test_irq_flow();
        test_collisions();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_timer.md
Name: mem_timer

Overview:
- Memory-mapped machine timer. It is a bus responder on the CPU data-memory port: memAddr, memWriteData, wrMask and memWr in, memReadData out.
- Holds a 64-bit free-running counter (mtime), a 64-bit compare register (mtimecmp), a prescaler, control and status registers.
- Raises a level interrupt toward the CPU interrupt controller (irqBus).
- Reads are combinational, for the single-cycle core. Writes commit on the clock edge.

Parameters:
- PRESCALE_W, 8, width of the prescaler divisor field and counter.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  block selected by the external address decoder.
- we  in  1  write enable (CPU memWr).
- addr  in  5  byte offset; only addr[4:2] is decoded, addr[1:0] is ignored.
- wrData  in  32  write data, already lane-shifted by the CPU.
- wrMask  in  4  byte-lane write enables.
- rdData  out  32  read data, combinational.
- irq  out  1  interrupt request, level.

Behaviour:
- Register map (addr[4:2]):
  - 0 MTIME_LO.
  - 1 MTIME_HI.
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 CTRL: [0] en, [1] ie, [8+PRESCALE_W-1:8] div.
  - 5 STATUS: [0] pend, write-1-to-clear.
  - 6, 7 unmapped: read 0, writes ignored.
- Reset values: mtime=0, mtimecmp=CMP_RESET, ctrl=0, pend=0, matchQ=0, hiShadow=0, prescaler count=0. rdData=0 and irq=0 during and after reset.
- Reads:
  - When sel=0, rdData=0.
  - When sel=1, rdData = selected register in the same cycle, with no latency.
  - Reading MTIME_HI returns hiShadow, not live mtime[63:32].
- Snapshot: a cycle with sel=1, we=0, addr[4:2]=0 latches mtime[63:32] into hiShadow at the clock edge. Software reads LO then HI for a coherent 64-bit value.
- Writes (sel & we at posedge):
  - Each byte lane with wrMask[i]=1 takes wrData[8i+7:8i].
  - Unmasked bytes keep their pre-edge value.
  - No carry propagates between bytes or halves.
- Prescaler:
  - While en=1, count increments each cycle.
  - When count==div, it emits a tick and count returns to 0. div=0 gives a tick every cycle.
  - While en=0, count holds at 0 and mtime holds.
  - Any write to CTRL or MTIME_LO/HI clears count to 0.
- Counter:
  - On a tick, mtime <= mtime+1, mod 2^64. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A software write to an MTIME half in the same cycle as a tick has priority for the whole 64-bit register: the tick is dropped that cycle.
- Compare:
  - match = (mtime >= mtimecmp), 64-bit unsigned, evaluated on register values.
  - matchQ <= match every cycle.
  - pend is set on the rising edge of match (match & ~matchQ), independent of en and ie.
- STATUS write clears pend only if wrData[0]=1 and wrMask[0]=1.
- If a set and a clear of pend occur in the same cycle, set wins.
- irq = pend & ie, from registers. No glitch path from the bus inputs.
- Lowering mtimecmp below mtime produces a rising edge of match, which sets pend one edge later.
- Reset asserted mid-count or mid-write: all state returns to reset values on that edge, and any write that cycle is discarded.

Decomposition:
- Shared constants header entries:
  - register offsets: TMR_MTIME_LO, TMR_MTIME_HI, TMR_MTIMECMP_LO, TMR_MTIMECMP_HI, TMR_CTRL, TMR_STATUS.
  - CTRL bit positions: TMR_CTRL_EN, TMR_CTRL_IE, TMR_CTRL_DIV_LSB.
- One sub-module: byte_merge, a parameterised 32-bit masked merge. It is used four times, once per 32-bit register half.
- Remaining logic (prescaler, counter, compare, pend) stays in mem_timer.

Test Plan:
- Reset check: assert reset 2 cycles, then read offsets 0x00–0x1C. Required: 0,0,FFFF_FFFF,FFFF_FFFF,0,0,0,0, and irq=0.
- Prescaler rate: write CTRL=0x0000_0301 (en=1, div=3), idle 40 cycles, read LO. Required: 10 (±1 for the write-edge alignment); the value steps once every 4 cycles.
- Wrap and snapshot: write MTIME_LO=FFFF_FFFE and MTIME_HI=FFFF_FFFF, with div=0, en=1. After 3 ticks, read LO then HI. Required: LO=1, HI=0. Then read HI without a prior LO read; it still returns 0.
- Byte mask: write MTIMECMP_LO with wrData=AABB_CCDD, wrMask=0100b. Read. Required: FFBB_FFFF.
- Interrupt flow:
  - Setup: mtimecmp=0x10, ie=1, en=1, div=0.
  - When mtime reaches 0x10, pend=1 on the next edge and irq=1.
  - Write STATUS=1. Required: pend=0 and irq=0 even though match is held.
  - Lower mtimecmp to 0x5. Required: no new pend (no rising edge).
  - Write mtime=0, then mtimecmp=0x3. Required: pend re-asserts at mtime=3.
- Collisions:
  - Write STATUS=1 on the exact cycle match rises. Required: pend=1.
  - Write MTIME_LO=0x100 on a tick cycle. Required: reads 0x100, not 0x101.
  - Assert reset during a write. Required: the write is discarded.
